// File: rtl/key_debounce.sv
// Two-key front end for the stopwatch: synchronise, debounce, and derive press and long-press pulses.
// Each key runs through an identical, independent key_debounce_chan instance.

module key_debounce_chan #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned LONG_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic level,
  output logic long_pulse
);

  localparam int unsigned CNT_W  = $clog2(DEB_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  logic              sync0;
  logic              sync1;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold;
  logic              accept_c;

  // sync1 has disagreed with level for DEB_CYCLES consecutive edges, counting this one
  assign accept_c = (sync1 != level) && (cnt == CNT_W'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      cnt        <= '0;
      level      <= 1'b0;
      pulse      <= 1'b0;
      hold       <= '0;
      long_pulse <= 1'b0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;

      if (sync1 == level) begin
        cnt <= '0;
      end else if (accept_c) begin
        level <= sync1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      pulse <= accept_c & sync1;

      // Hold time since acceptance; saturates so only one long pulse per press
      if (!level) begin
        hold <= '0;
      end else if (hold != HOLD_W'(LONG_CYCLES)) begin
        hold <= hold + HOLD_W'(1);
      end

      long_pulse <= level && (hold == HOLD_W'(LONG_CYCLES - 1));
    end
  end

endmodule

module key_debounce #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned LONG_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic sp_raw,
  input  logic rev_raw,
  output logic sp_pulse,
  output logic rev_pulse,
  output logic sp_level,
  output logic rev_level,
  output logic sp_long,
  output logic rev_long
);

  key_debounce_chan #(
    .DEB_CYCLES (DEB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES)
  ) u_sp (
    .clk       (clk),
    .rst       (rst),
    .raw       (sp_raw),
    .pulse     (sp_pulse),
    .level     (sp_level),
    .long_pulse(sp_long)
  );

  key_debounce_chan #(
    .DEB_CYCLES (DEB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES)
  ) u_rev (
    .clk       (clk),
    .rst       (rst),
    .raw       (rev_raw),
    .pulse     (rev_pulse),
    .level     (rev_level),
    .long_pulse(rev_long)
  );

endmodule
